// File: rtl/uart_pkg.sv
// Shared UART definitions: controller states, frame sizing, line levels and parity.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_width(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

  // Payload is zero-extended to 9 bits; padding does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter with synchronous clear; tick marks count 0, last marks the wrap.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == '0);
  assign last = (cnt == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte, builds the serial frame and strobes the
// downstream shift register once per bit period. All outputs come straight from flops.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  localparam int FRAME_W     = frame_width(DATA_BITS, PARITY_EN, STOP_BITS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [FRAME_W-1:0]   frame,
  output logic                 load,
  output logic                 shift,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = $clog2(FRAME_W + 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_ctrl: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  uart_state_e        state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] frame_nxt;
  logic               accept;
  logic               baud_clr, baud_tick, baud_last;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (baud_clr),
    .tick    (baud_tick),
    .last    (baud_last)
  );

  assign accept   = (state == ST_IDLE) && tx_ready && tx_valid;
  assign baud_clr = (state == ST_LOAD);

  always_comb begin
    frame_nxt               = {FRAME_W{STOP_BIT}};
    frame_nxt[0]            = START_BIT;
    frame_nxt[DATA_BITS:1]  = tx_data;
    if (PARITY_EN != 0) begin
      frame_nxt[DATA_BITS+1] = parity_bit(9'(tx_data), PARITY_ODD != 0);
    end
  end

  // The frame ends when the period after the last shift strobe wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (baud_last && bit_cnt == BIT_W'(FRAME_W)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_ready <= 1'b0;
      load     <= 1'b0;
      shift    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      frame    <= '1;
      bit_cnt  <= '0;
    end else begin
      tx_ready <= (state_nxt == ST_IDLE);
      load     <= (state_nxt == ST_LOAD);
      shift    <= (state_nxt == ST_SHIFT) && (baud_clr || baud_last);
      busy     <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT);
      done     <= (state_nxt == ST_DONE);
      if (accept) begin
        frame <= frame_nxt;
      end
      if (state == ST_LOAD) begin
        bit_cnt <= '0;
      end else if (state == ST_SHIFT && baud_tick) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Drives four controller configurations with shared stimulus and compares every cycle
// against a frame-timing model derived from cycle offsets since the accepting edge.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // cfg0: 8N1, cfg1: 8E1, cfg2: 8O1, cfg3: 8N2
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 2 : 1;
    localparam int F  = 1 + 8 + PE + SB;

    logic         tx_ready, load, shift, busy, done;
    logic [F-1:0] frame;

    uart_tx_ctrl #(
      .DATA_BITS    (8),
      .CLKS_PER_BIT (CPB),
      .PARITY_EN    (PE),
      .PARITY_ODD   (PO),
      .STOP_BITS    (SB)
    ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .frame    (frame),
      .load     (load),
      .shift    (shift),
      .busy     (busy),
      .done     (done)
    );

    function automatic logic [F-1:0] ref_frame(input logic [7:0] d);
      logic [F-1:0] f;
      int ones;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      ones = $countones(d);
      if (PE == 1) f[9] = (PO == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      return f;
    endfunction

    bit           started  = 0;
    bit           m_ready  = 0;
    bit           m_active = 0;
    int           m_c      = 0;
    logic [F-1:0] m_frame  = '1;
    bit           e_load, e_shift, e_busy, e_done;

    always @(posedge clk) begin
      started = 1;
      if (!reset_n) begin
        m_ready  = 0;
        m_active = 0;
        m_frame  = '1;
      end else if (m_active) begin
        m_c++;
        if (m_c == 3 + F * CPB) begin
          m_active = 0;
          m_ready  = 1;
        end
      end else if (m_ready && tx_valid) begin
        m_active = 1;
        m_c      = 1;
        m_ready  = 0;
        m_frame  = ref_frame(tx_data);
      end else begin
        m_ready = 1;
      end
    end

    always @(negedge clk) begin
      if (started) begin
        e_load  = m_active && m_c == 1;
        e_shift = m_active && m_c >= 2 && ((m_c - 2) % CPB == 0) && ((m_c - 2) / CPB < F);
        e_done  = m_active && m_c == 2 + F * CPB;
        e_busy  = m_active && m_c >= 1 && m_c <= 1 + F * CPB;
        check_eq($sformatf("c%0d.tx_ready", g), 32'(tx_ready), 32'(m_ready));
        check_eq($sformatf("c%0d.load", g), 32'(load), 32'(e_load));
        check_eq($sformatf("c%0d.shift", g), 32'(shift), 32'(e_shift));
        check_eq($sformatf("c%0d.busy", g), 32'(busy), 32'(e_busy));
        check_eq($sformatf("c%0d.done", g), 32'(done), 32'(e_done));
        check_eq($sformatf("c%0d.frame", g), 32'(frame), 32'(m_frame));
      end
    end
  end

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    send(8'hA5);
    check_eq("t1.frame", 32'(g_cfg[0].frame), 32'h34A);
    check_eq("t1.load", 32'(g_cfg[0].load), 32'h1);
    repeat (14) @(negedge clk);
    send(8'h3C);
    repeat (40) @(negedge clk);
    check_eq("t4.frame_kept", 32'(g_cfg[0].frame), 32'h34A);
    repeat (10) @(negedge clk);

    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    check_eq("t2.frame0", 32'(g_cfg[0].frame), 32'h200);
    repeat (4) @(negedge clk);
    tx_data = 8'hFF;
    repeat (40) @(negedge clk);
    check_eq("t2.frame1", 32'(g_cfg[0].frame), 32'h3FE);
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);

    send(8'h07);
    check_eq("t3.even", 32'(g_cfg[1].frame), 32'h60E);
    check_eq("t3.odd", 32'(g_cfg[2].frame), 32'h40E);
    repeat (60) @(negedge clk);

    send(8'hA5);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("t5.frame_rst", 32'(g_cfg[0].frame), 32'h3FF);
    check_eq("t5.busy_rst", 32'(g_cfg[0].busy), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h55);
    check_eq("t5.frame", 32'(g_cfg[0].frame), 32'h2AA);
    repeat (60) @(negedge clk);

    send(8'h81);
    check_eq("t6.frame", 32'(g_cfg[3].frame), 32'h702);
    repeat (60) @(negedge clk);

    for (int i = 0; i < 4000; i++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      reset_n  = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    reset_n  = 1'b1;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller, directly upstream of the transmit shift register. It accepts a byte over a valid/ready handshake and builds the serial frame: start bit, data LSB-first, optional parity, then stop bit(s). It then drives the shift register's parallel-load and per-bit shift strobes at the baud rate. It reports busy/done to the host side.

Parameters:
DATA_BITS, 8, payload width (5..9).
CLKS_PER_BIT, 434, clock cycles per bit period; must be >= 2 (elaboration-time check).
PARITY_EN, 0, 1 appends a parity bit after the data.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, 1 or 2.
FRAME_W (localparam), 1+DATA_BITS+PARITY_EN+STOP_BITS, frame width.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
tx_data  input  DATA_BITS  byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  controller can accept; transfer occurs when tx_valid && tx_ready at a rising edge
frame  output  FRAME_W  parallel frame to the shift register; bit 0 is sent first
load  output  1  one-cycle parallel-load strobe
shift  output  1  one-cycle per-bit shift strobe
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last bit period completes

Behaviour:
- One clock. Reset is synchronous and active-low: sampled only at posedge clk.
- All outputs are registered.
- Reset values: tx_ready=0, load=0, shift=0, busy=0, done=0, frame=all ones (idle line level), state=IDLE, counters=0.
- tx_ready rises at the first edge with reset_n high.
- Frame format:
  - frame[0]=0 (start bit).
  - frame[DATA_BITS:1]=tx_data, LSB at index 1.
  - If PARITY_EN: frame[DATA_BITS+1] = ^tx_data ^ PARITY_ODD.
  - All remaining upper bits = 1 (stop bits).
- frame holds from load until the next accepted transfer.
- States: IDLE, LOAD, SHIFT, DONE.
  - IDLE: tx_ready=1. On handshake, capture tx_data, build the frame, clear tx_ready, go to LOAD.
  - LOAD: load=1 and busy=1 for exactly one cycle; clear baud_cnt and bit_cnt; go to SHIFT.
  - SHIFT: baud_cnt counts 0..CLKS_PER_BIT-1 and wraps. shift=1 on each cycle where baud_cnt==0, and bit_cnt increments on that cycle. After FRAME_W shift strobes and the final full bit period, go to DONE.
  - DONE: done=1, busy=0 for one cycle; return to IDLE with tx_ready=1.
- Timing: cycle 0 is the handshake edge.
  - load high in cycle 1.
  - shift high in cycles 2 + k*CLKS_PER_BIT, for k = 0..FRAME_W-1.
  - done high in cycle 2 + FRAME_W*CLKS_PER_BIT.
  - tx_ready high from cycle 3 + FRAME_W*CLKS_PER_BIT.
  - busy high in cycles 1 .. 1 + FRAME_W*CLKS_PER_BIT.
- load and shift are never high in the same cycle. shift never occurs outside SHIFT.
- tx_valid while tx_ready=0 is ignored. tx_data/tx_valid are never sampled mid-frame. No buffering, no overrun flag.
- tx_valid held continuously gives back-to-back frames separated only by the DONE and IDLE cycles.
- Reset mid-frame aborts the frame. All outputs take their reset values at that edge. No done pulse; no partial frame resumes.
- bit_cnt is sized clog2(FRAME_W+1). baud_cnt is sized clog2(CLKS_PER_BIT). Neither overflows.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef;
  - a frame-width function of (DATA_BITS, PARITY_EN, STOP_BITS);
  - START_BIT=0 and STOP_BIT=1 constants;
  - a parity helper function.
- One sub-module, uart_baud_gen: counter with a synchronous clear and a tick output when the count is 0, parameterised by CLKS_PER_BIT. It is reused by the future receiver.

Test Plan:
1. CLKS_PER_BIT=4, 8N1. Reset, then send 0xA5 at cycle 0 -> frame=0x34A, load in cycle 1, shift in cycles 2,6,...,38 (10 pulses), done in cycle 42, tx_ready in cycle 43.
2. tx_valid held high with 0x00 then 0xFF -> first frame 0x200, second accepted at cycle 43, frame 0x3FE, exactly 10 shifts each.
3. PARITY_EN=1, even, send 0x07 -> frame=0x60E (11 bits). Odd parity, same byte -> 0x40E.
4. Pulse tx_valid with 0x3C during cycle 15 of a 0xA5 frame -> ignored: frame stays 0x34A, no extra load, tx_ready stays 0 until cycle 43.
5. Assert reset_n=0 at cycle 20 of a frame -> next edge: busy=0, shift=0, frame=0x3FF, no done. After release, send 0x55 -> normal frame 0x2AA with timing as in test 1.
6. STOP_BITS=2, send 0x81 -> frame=0x702, 11 shifts, done in cycle 46.
